// File: rtl/mealy_pattern_detector.sv
// Serial Mealy detector for a parameterised bit pattern.
// The state is the number of pattern bits matched so far. The next-state
// table is built from PATTERN when the design is elaborated, using the
// KMP failure rule. The detect flag is combinational: it goes high in the
// same cycle that the final qualifying bit is presented.
module mealy_pattern_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    input  logic valid_i,
    output logic pattern
);

    localparam int SW = $clog2(PAT_LEN);

    typedef enum logic [SW-1:0] {
        S_0    = '0,
        S_LAST = SW'(PAT_LEN - 1)
    } state_t;

    // Next state after seeing bit b while k bits are matched.
    // The received history is the first k pattern bits followed by b.
    // The result is the longest suffix of that history which is also a
    // pattern prefix, capped below PAT_LEN. A clean match therefore
    // advances to k+1, and a completed match falls back to the pattern's
    // self-overlap. In non-overlapping mode a completed match restarts at zero.
    function automatic logic [SW-1:0] kmp_next(input int k, input logic b);
        logic [PAT_LEN:0] hist;
        int               best;
        logic             ok;
        hist = '0;
        best = 0;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (i < k) begin
                hist[i] = PATTERN[PAT_LEN-1-i];
            end
        end
        hist[k] = b;
        if ((k == PAT_LEN - 1) && (b == PATTERN[0]) && !OVERLAP) begin
            return '0;
        end
        for (int j = 1; j < PAT_LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int m = 0; m < j; m++) begin
                    if (hist[k+1-j+m] != PATTERN[PAT_LEN-1-m]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return SW'(best);
    endfunction

    logic [SW-1:0] next_tbl [2**SW][2];

    for (genvar gk = 0; gk < 2**SW; gk++) begin : g_tbl
        if (gk < PAT_LEN) begin : g_live
            assign next_tbl[gk][0] = kmp_next(gk, 1'b0);
            assign next_tbl[gk][1] = kmp_next(gk, 1'b1);
        end else begin : g_unused
            assign next_tbl[gk][0] = '0;
            assign next_tbl[gk][1] = '0;
        end
    end

    state_t state_q;
    state_t state_d;

    // State register, asynchronously cleared so no match can span a reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_0;
        end else begin
            state_q <= state_d;
        end
    end

    // Table-driven transition and Mealy detect, both gated by valid_i
    always_comb begin
        state_d = state_q;
        pattern = 1'b0;
        if (valid_i) begin
            state_d = state_t'(next_tbl[state_q][d_i]);
            pattern = (state_q == S_LAST) && (d_i == PATTERN[0]);
        end
    end

endmodule

// File: tb/tb_mealy_pattern_detector.sv
// Directed and seeded-random checks for the Mealy pattern detector.
// The bench runs an overlapping and a non-overlapping instance side by side.
module tb_mealy_pattern_detector;

    logic clk;
    logic rst;
    logic d_i;
    logic valid_i;
    logic pattern_ovl;
    logic pattern_novl;

    int checks;
    int errors;
    int edges_ovl;
    int edges_novl;
    logic prev_ovl;
    logic prev_novl;

    mealy_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) dut_ovl (
        .clk     (clk),
        .rst     (rst),
        .d_i     (d_i),
        .valid_i (valid_i),
        .pattern (pattern_ovl)
    );

    mealy_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) dut_novl (
        .clk     (clk),
        .rst     (rst),
        .d_i     (d_i),
        .valid_i (valid_i),
        .pattern (pattern_novl)
    );

    // Free-running clock with a 10-time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic b);
        @(negedge clk);
        valid_i = v;
        d_i     = b;
        #1;
        if (pattern_ovl && !prev_ovl) edges_ovl++;
        if (pattern_novl && !prev_novl) edges_novl++;
        prev_ovl  = pattern_ovl;
        prev_novl = pattern_novl;
    endtask

    task automatic stepCheck(input string tag, input logic v, input logic b,
                             input logic exp_ovl, input logic exp_novl);
        applyStimulus(v, b);
        checkOutput({tag, "_ovl"}, 32'(pattern_ovl), 32'(exp_ovl));
        checkOutput({tag, "_novl"}, 32'(pattern_novl), 32'(exp_novl));
    endtask

    task automatic pulseReset();
        @(negedge clk);
        valid_i = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    // Reference model state for the random soak
    logic [3:0] hist;
    int   seen_ovl;
    int   seen_novl;
    int   model_edges_ovl;
    int   model_edges_novl;
    int   cycle_errs;
    logic mprev_ovl;
    logic mprev_novl;
    logic [3:0] window;
    logic exp_o;
    logic exp_n;
    logic rbit;

    // Main sequence of directed tests followed by the random soak
    initial begin
        logic [6:0] seq_bits;
        logic [6:0] seq_ovl;
        logic [6:0] seq_novl;
        checks = 0;
        errors = 0;
        edges_ovl = 0;
        edges_novl = 0;
        prev_ovl = 1'b0;
        prev_novl = 1'b0;
        rst = 1'b0;
        valid_i = 1'b1;
        d_i = 1'b1;

        // Held in reset with a tempting input: flag must stay low
        stepCheck("rst_hold0", 1'b1, 1'b1, 1'b0, 1'b0);
        stepCheck("rst_hold1", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        valid_i = 1'b0;
        rst = 1'b1;

        // Overlapping vs non-overlapping on 1011011
        seq_bits = 7'b1011011;
        seq_ovl  = 7'b0001001;
        seq_novl = 7'b0001000;
        edges_ovl = 0;
        edges_novl = 0;
        for (int i = 6; i >= 0; i--) begin
            stepCheck($sformatf("seq_b%0d", 6 - i), 1'b1, seq_bits[i], seq_ovl[i], seq_novl[i]);
        end
        stepCheck("seq_idle", 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("seq_edges_ovl", 32'(edges_ovl), 32'd2);
        checkOutput("seq_edges_novl", 32'(edges_novl), 32'd1);

        // Valid gaps: state held, d_i ignored while valid_i is low
        pulseReset();
        stepCheck("gap_b0", 1'b1, 1'b1, 1'b0, 1'b0);
        stepCheck("gap_b1", 1'b1, 1'b0, 1'b0, 1'b0);
        stepCheck("gap_i0", 1'b0, 1'b1, 1'b0, 1'b0);
        stepCheck("gap_i1", 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("gap_i2", 1'b0, 1'b1, 1'b0, 1'b0);
        stepCheck("gap_b2", 1'b1, 1'b1, 1'b0, 1'b0);
        stepCheck("gap_b3", 1'b1, 1'b1, 1'b1, 1'b1);

        // Completing bit presented without valid must not fire
        pulseReset();
        stepCheck("nv_b0", 1'b1, 1'b1, 1'b0, 1'b0);
        stepCheck("nv_b1", 1'b1, 1'b0, 1'b0, 1'b0);
        stepCheck("nv_b2", 1'b1, 1'b1, 1'b0, 1'b0);
        stepCheck("nv_hold", 1'b0, 1'b1, 1'b0, 1'b0);
        stepCheck("nv_fire", 1'b1, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset mid-sequence wipes the partial match
        pulseReset();
        stepCheck("mid_b0", 1'b1, 1'b1, 1'b0, 1'b0);
        stepCheck("mid_b1", 1'b1, 1'b0, 1'b0, 1'b0);
        stepCheck("mid_b2", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        valid_i = 1'b1;
        d_i = 1'b1;
        #1;
        checkOutput("mid_armed_ovl", 32'(pattern_ovl), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("mid_inrst_ovl", 32'(pattern_ovl), 32'd0);
        checkOutput("mid_inrst_novl", 32'(pattern_novl), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("mid_post_ovl", 32'(pattern_ovl), 32'd0);
        stepCheck("mid_b4", 1'b1, 1'b0, 1'b0, 1'b0);
        stepCheck("mid_b5", 1'b1, 1'b1, 1'b0, 1'b0);
        stepCheck("mid_b6", 1'b1, 1'b1, 1'b1, 1'b1);

        // Random soak against a sliding-window reference model
        pulseReset();
        void'($urandom(123456));
        hist = '0;
        seen_ovl = 0;
        seen_novl = 0;
        model_edges_ovl = 0;
        model_edges_novl = 0;
        mprev_ovl = 1'b0;
        mprev_novl = 1'b0;
        cycle_errs = 0;
        edges_ovl = 0;
        edges_novl = 0;
        prev_ovl = 1'b0;
        prev_novl = 1'b0;
        for (int n = 0; n < 540; n++) begin
            rbit = 1'($urandom_range(0, 1));
            window = {hist[2:0], rbit};
            exp_o = (window == 4'b1011) && (seen_ovl >= 3);
            exp_n = (window == 4'b1011) && (seen_novl >= 3);
            applyStimulus(1'b1, rbit);
            if (pattern_ovl !== exp_o || pattern_novl !== exp_n) cycle_errs++;
            if (exp_o && !mprev_ovl) model_edges_ovl++;
            if (exp_n && !mprev_novl) model_edges_novl++;
            mprev_ovl = exp_o;
            mprev_novl = exp_n;
            hist = window;
            seen_ovl++;
            seen_novl = exp_n ? 0 : seen_novl + 1;
        end
        stepCheck("soak_idle", 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("soak_edges_ovl", 32'(edges_ovl), 32'(model_edges_ovl));
        checkOutput("soak_edges_novl", 32'(edges_novl), 32'(model_edges_novl));
        checkOutput("soak_cycles", 32'(cycle_errs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
